// File: rtl/count_bin_nios2_gen2_0_cpu_debug_mem_seq.sv
// Runs decoded JTAG debug commands as single-word Avalon-MM accesses and
// maintains the monitor address/data registers seen by the debug-slave TCK side.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no access in flight; accepts ocimem_a / ocimem_b / no_action_a
// S_READ  | avm_read held until waitrequest drops or the stall limit hits
// S_WRITE | avm_write held until waitrequest drops or the stall limit hits
module count_bin_nios2_gen2_0_cpu_debug_mem_seq #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic [ADDR_W-1:0] MonAReg,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mona_q, mona_d;
  logic [31:0]       mond_q, mond_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;
  logic [15:0]       stall_q, stall_d;

  logic [ADDR_W-1:0] f_addr;
  logic [31:0]       f_data;
  logic              f_rd;
  logic              any_cmd;
  logic              dropped;
  logic              unused_jdo;

  assign f_addr     = jdo[ADDR_W+2:3];
  assign f_data     = jdo[34:3];
  assign f_rd       = jdo[35];
  assign unused_jdo = ^jdo[37:36];

  assign any_cmd = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  // Any strobe that loses the same-cycle priority contest is discarded.
  assign dropped = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a)) |
                   (take_action_ocimem_b & take_no_action_ocimem_a);

  always_comb begin
    state_d = state_q;
    mona_d  = mona_q;
    mond_d  = mond_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    read_d  = read_q;
    write_d = write_q;
    rdy_d   = rdy_q;
    err_d   = err_q;
    stall_d = stall_q;

    case (state_q)
      S_IDLE: begin
        if (take_action_ocimem_a) begin
          mona_d = f_addr;
          err_d  = 1'b0;
          rdy_d  = 1'b0;
          if (f_rd) begin
            state_d = S_READ;
            read_d  = 1'b1;
            addr_d  = f_addr;
            stall_d = '0;
          end else begin
            rdy_d = 1'b1;
          end
        end else if (take_action_ocimem_b) begin
          mond_d  = f_data;
          wdata_d = f_data;
          state_d = S_WRITE;
          write_d = 1'b1;
          addr_d  = mona_q;
          rdy_d   = 1'b0;
          stall_d = '0;
        end else if (take_no_action_ocimem_a) begin
          state_d = S_READ;
          read_d  = 1'b1;
          addr_d  = mona_q;
          rdy_d   = 1'b0;
          stall_d = '0;
        end
      end
      S_READ, S_WRITE: begin
        if (any_cmd) err_d = 1'b1;
        if (!avm_waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (state_q == S_READ) mond_d = avm_readdata;
          mona_d  = mona_q + ADDR_W'(1);
          rdy_d   = 1'b1;
          state_d = S_IDLE;
        end else if (stall_q == STALL_LAST) begin
          // Abandon the access: registers keep their pre-access values.
          read_d  = 1'b0;
          write_d = 1'b0;
          err_d   = 1'b1;
          rdy_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          stall_d = stall_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase

    if (dropped) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mona_q  <= '0;
      mond_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      mona_q  <= mona_d;
      mond_q  <= mond_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      read_q  <= read_d;
      write_q <= write_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign avm_address   = addr_q;
  assign avm_read      = read_q;
  assign avm_write     = write_q;
  assign avm_writedata = wdata_q;
  assign MonAReg       = mona_q;
  assign MonDReg       = mond_q;
  assign monitor_ready = rdy_q;
  assign monitor_error = err_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_count_bin_nios2_gen2_0_cpu_debug_mem_seq.sv
// Directed bench: stimulus pushes expected bus accesses into a queue, an
// independent monitor pops and checks each completed Avalon handshake.
module tb_count_bin_nios2_gen2_0_cpu_debug_mem_seq;
  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [37:0]       jdo = '0;
  logic              sa = 1'b0, sb = 1'b0, sn = 1'b0;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read, avm_write;
  logic [31:0]       avm_writedata, avm_readdata;
  logic              avm_waitrequest = 1'b0;
  logic [ADDR_W-1:0] MonAReg;
  logic [31:0]       MonDReg;
  logic              monitor_ready, monitor_error, busy;

  logic [31:0] mem [0:1023];

  typedef struct {
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  count_bin_nios2_gen2_0_cpu_debug_mem_seq #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(sa), .take_action_ocimem_b(sb), .take_no_action_ocimem_a(sn),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .MonAReg(MonAReg), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error), .busy(busy)
  );

  always #5 clk = ~clk;

  assign avm_readdata = mem[avm_address];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic logic [37:0] mk(input logic rd, input logic [31:0] d);
    return {2'b00, rd, d, 3'b000};
  endfunction

  task automatic push_exp(input logic w, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    exp_t e;
    e.is_wr = w;
    e.addr  = a;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic strobe(input logic a, input logic b, input logic n, input logic [37:0] j);
    cyc();
    jdo = j;
    sa  = a;
    sb  = b;
    sn  = n;
    cyc();
    sa  = 1'b0;
    sb  = 1'b0;
    sn  = 1'b0;
  endtask

  // Bus monitor: checks exclusivity and each completed handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (avm_read || avm_write)) begin
      chk("rd_wr_exclusive", {31'b0, avm_read & avm_write}, 32'd0);
      if (!avm_waitrequest) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_access: got addr %h wr %b expected none", avm_address, avm_write);
        end else begin
          e = exp_q.pop_front();
          chk("acc_kind", {31'b0, avm_write}, {31'b0, e.is_wr});
          chk("acc_addr", {22'b0, avm_address}, {22'b0, e.addr});
          if (e.is_wr) begin
            chk("acc_wdata", avm_writedata, e.data);
            mem[avm_address] = avm_writedata;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10'h3FF] = 32'h12345678;
    mem[10'h040] = 32'hCAFEF00D;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mona",  {22'b0, MonAReg}, 32'h0);
    chk("rst_mond",  MonDReg, 32'h0);
    chk("rst_ready", {31'b0, monitor_ready}, 32'd0);
    chk("rst_error", {31'b0, monitor_error}, 32'd0);
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    chk("rst_read",  {31'b0, avm_read}, 32'd0);
    chk("rst_write", {31'b0, avm_write}, 32'd0);
    reset = 1'b0;

    // Address load without read
    strobe(1'b1, 1'b0, 1'b0, mk(1'b0, 32'h010));
    @(negedge clk);
    chk("load_mona",  {22'b0, MonAReg}, 32'h010);
    chk("load_ready", {31'b0, monitor_ready}, 32'd1);
    chk("load_busy",  {31'b0, busy}, 32'd0);
    chk("load_read",  {31'b0, avm_read}, 32'd0);

    // Zero-wait write
    push_exp(1'b1, 10'h010, 32'hDEADBEEF);
    strobe(1'b0, 1'b1, 1'b0, mk(1'b0, 32'hDEADBEEF));
    @(negedge clk);
    chk("wr_active", {31'b0, avm_write}, 32'd1);
    chk("wr_busy",   {31'b0, busy}, 32'd1);
    chk("wr_ready0", {31'b0, monitor_ready}, 32'd0);
    chk("wr_mond",   MonDReg, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_done",   {31'b0, avm_write}, 32'd0);
    chk("wr_mona",   {22'b0, MonAReg}, 32'h011);
    chk("wr_ready1", {31'b0, monitor_ready}, 32'd1);

    // Load with read-back
    push_exp(1'b0, 10'h010, 32'h0);
    strobe(1'b1, 1'b0, 1'b0, mk(1'b1, 32'h010));
    @(negedge clk);
    chk("rb_read",   {31'b0, avm_read}, 32'd1);
    chk("rb_ready0", {31'b0, monitor_ready}, 32'd0);
    @(negedge clk);
    chk("rb_mond",   MonDReg, 32'hDEADBEEF);
    chk("rb_mona",   {22'b0, MonAReg}, 32'h011);
    chk("rb_ready1", {31'b0, monitor_ready}, 32'd1);
    chk("rb_error",  {31'b0, monitor_error}, 32'd0);

    // Wait states and address wrap
    strobe(1'b1, 1'b0, 1'b0, mk(1'b0, 32'h3FF));
    @(negedge clk);
    chk("wrap_load", {22'b0, MonAReg}, 32'h3FF);
    avm_waitrequest = 1'b1;
    push_exp(1'b0, 10'h3FF, 32'h0);
    strobe(1'b0, 1'b0, 1'b1, 38'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("wait_read", {31'b0, avm_read}, 32'd1);
      chk("wait_addr", {22'b0, avm_address}, 32'h3FF);
      cyc();
      if (i == 4) avm_waitrequest = 1'b0;
    end
    @(negedge clk);
    chk("wait_done",  {31'b0, avm_read}, 32'd0);
    chk("wait_mond",  MonDReg, 32'h12345678);
    chk("wrap_mona",  {22'b0, MonAReg}, 32'h000);
    chk("wait_ready", {31'b0, monitor_ready}, 32'd1);

    // Timeout
    strobe(1'b1, 1'b0, 1'b0, mk(1'b0, 32'h020));
    avm_waitrequest = 1'b1;
    strobe(1'b0, 1'b0, 1'b1, 38'h0);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      chk("to_read_held", {31'b0, avm_read}, 32'd1);
      cyc();
    end
    @(negedge clk);
    chk("to_read_drop", {31'b0, avm_read}, 32'd0);
    chk("to_error",     {31'b0, monitor_error}, 32'd1);
    chk("to_ready",     {31'b0, monitor_ready}, 32'd0);
    chk("to_mona",      {22'b0, MonAReg}, 32'h020);
    chk("to_mond",      MonDReg, 32'h12345678);
    chk("to_busy",      {31'b0, busy}, 32'd0);
    avm_waitrequest = 1'b0;
    strobe(1'b1, 1'b0, 1'b0, mk(1'b0, 32'h040));
    @(negedge clk);
    chk("clr_error", {31'b0, monitor_error}, 32'd0);
    chk("clr_ready", {31'b0, monitor_ready}, 32'd1);
    chk("clr_mona",  {22'b0, MonAReg}, 32'h040);

    // Write strobe during a read
    avm_waitrequest = 1'b1;
    push_exp(1'b0, 10'h040, 32'h0);
    strobe(1'b0, 1'b0, 1'b1, 38'h0);
    strobe(1'b0, 1'b1, 1'b0, mk(1'b0, 32'h11111111));
    @(negedge clk);
    chk("col_error", {31'b0, monitor_error}, 32'd1);
    chk("col_busy",  {31'b0, busy}, 32'd1);
    chk("col_read",  {31'b0, avm_read}, 32'd1);
    chk("col_write", {31'b0, avm_write}, 32'd0);
    chk("col_mond0", MonDReg, 32'h12345678);
    cyc();
    avm_waitrequest = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("col_ready", {31'b0, monitor_ready}, 32'd1);
    chk("col_mond",  MonDReg, 32'hCAFEF00D);
    chk("col_mona",  {22'b0, MonAReg}, 32'h041);
    chk("col_err_sticky", {31'b0, monitor_error}, 32'd1);

    // ocimem_a and ocimem_b together
    strobe(1'b1, 1'b1, 1'b0, mk(1'b0, 32'h055));
    @(negedge clk);
    chk("ab_mona",  {22'b0, MonAReg}, 32'h055);
    chk("ab_error", {31'b0, monitor_error}, 32'd1);
    chk("ab_busy",  {31'b0, busy}, 32'd0);
    chk("ab_write", {31'b0, avm_write}, 32'd0);
    chk("ab_mond",  MonDReg, 32'hCAFEF00D);

    // Asynchronous reset in the middle of a stalled write
    avm_waitrequest = 1'b1;
    strobe(1'b0, 1'b1, 1'b0, mk(1'b0, 32'hA5A5A5A5));
    @(negedge clk);
    chk("ar_write_on", {31'b0, avm_write}, 32'd1);
    chk("ar_addr",     {22'b0, avm_address}, 32'h055);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_write", {31'b0, avm_write}, 32'd0);
    chk("ar_busy",  {31'b0, busy}, 32'd0);
    chk("ar_mona",  {22'b0, MonAReg}, 32'h0);
    chk("ar_mond",  MonDReg, 32'h0);
    chk("ar_error", {31'b0, monitor_error}, 32'd0);
    chk("ar_ready", {31'b0, monitor_ready}, 32'd0);
    cyc();
    cyc();
    avm_waitrequest = 1'b0;
    reset = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    chk("post_write", {31'b0, avm_write}, 32'd0);
    chk("post_read",  {31'b0, avm_read}, 32'd0);
    chk("post_busy",  {31'b0, busy}, 32'd0);
    chk("post_ready", {31'b0, monitor_ready}, 32'd0);

    chk("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
